spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
Byte-oriented SPI master engine inside the RFID core. It drives the external sck/mosi/miso/cs pins that the board top routes to the transceiver front-end and the auxiliary SPI device. Upstream control logic hands it bytes over a valid/ready handshake and receives the captured miso bytes. The engine runs SPI mode 0 (CPOL=0, CPHA=0), MSB first. Chip select stays asserted across multi-byte bursts.

Parameters:
CLK_DIV, 25, clk cycles per sck half-period (50 MHz clk gives 1 MHz sck); legal values are 3 or more
NUM_CS, 2, number of active-low chip selects
CSW, 1, width of tx_cs_sel, equal to max(1, clog2(NUM_CS))

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_valid  in  1  upstream byte offer
tx_ready  out  1  engine can accept a byte
tx_data  in  8  byte to transmit
tx_last  in  1  byte is the last of its burst; cs releases after it
tx_cs_sel  in  CSW  target device; sampled only on the first byte of a burst
rx_valid  out  1  one-cycle pulse; rx_data is valid
rx_data  out  8  byte captured from miso
busy  out  1  high whenever state is not IDLE
state_o  out  3  state encoding for the debug LEDs
sck  out  1  SPI clock, registered
mosi  out  1  SPI data out, registered
miso  in  1  SPI data in, asynchronous
cs  out  NUM_CS  active-low chip selects, registered

Behaviour:
- Reset, applied on the next clk edge after rst goes high:
  - cs all ones, sck=0, mosi=0, rx_valid=0, rx_data=0, busy=0, state=IDLE.
  - tx_ready=0 while rst is high.
- miso passes through a 2-flop synchronizer before use.
- State encoding for state_o: IDLE=0, SETUP=1, HIGH=2, LOW=3, DONE=4, WAIT_NEXT=5, HOLD=6, GAP=7.
- IDLE: tx_ready=1, cs all ones, sck=0.
  - On tx_valid&tx_ready: latch tx_data, tx_last and tx_cs_sel; drive cs[sel]=0 and mosi=tx_data[7]; go to SETUP.
  - If sel >= NUM_CS, no cs bit asserts but the transfer still clocks normally.
- SETUP: sck=0 for CLK_DIV cycles, then go to HIGH with bit index 7.
- HIGH: sck=1 for CLK_DIV cycles. On the last cycle, shift the synchronized miso into the rx shift register LSB.
- LOW: sck=0 for CLK_DIV cycles.
  - On the first LOW cycle, mosi takes the next lower bit. After bit 0, mosi holds bit 0.
  - After CLK_DIV cycles: if bit index is 0, go to DONE; otherwise decrement and go to HIGH.
- Byte timing: exactly 8 sck rising edges per byte.
- DONE (1 cycle):
  - rx_valid=1 and rx_data=shift register.
  - The first DONE cycle occurs 17*CLK_DIV cycles after the accept cycle.
  - If the latched last=1, go to HOLD; otherwise go to WAIT_NEXT.
- WAIT_NEXT: cs stays low, sck=0, tx_ready=1, indefinitely.
  - On handshake: latch data and last, ignore tx_cs_sel, drive mosi=tx_data[7], go to SETUP.
- HOLD: CLK_DIV cycles with cs still low, then cs all ones and go to GAP.
- GAP: CLK_DIV cycles with cs high, then go to IDLE.
- tx_ready is 0 in every state except IDLE and WAIT_NEXT. tx_valid outside those states is ignored and no byte is lost; upstream must hold the byte.
- Counters:
  - Half-period counter is clog2(CLK_DIV+1) bits, reloads on every state entry, no wrap.
  - Bit index is 3 bits, counting 7 down to 0.
- Reset mid-operation: on the next edge, cs all ones, sck=0, state=IDLE. rx_valid is never emitted for a partial byte.
- rx_valid and a new accept never coincide; DONE has tx_ready=0.

Test Plan:
1. Reset. CLK_DIV=4, rst high for 3 cycles → cs=2'b11, sck=0, mosi=0, busy=0, tx_ready=0. The first cycle after rst falls shows tx_ready=1.
2. Single byte, loopback. Send 0xA5 to cs_sel=0 with last=1 and miso looped to mosi → cs=2'b10 during the transfer; exactly 8 sck rises; mosi bits 1,0,1,0,0,1,0,1; rx_valid at accept+68 with rx_data=0xA5; cs=2'b11 five cycles after DONE; tx_ready=1 after 4 more cycles.
3. Two-byte burst. Send 0x3C (last=0) then 0xC3 (last=1) on cs_sel=1 with miso=1 → cs[1] low continuously with no high glitch between bytes; two rx_valid pulses, both 0xFF; cs[0] stays 1 throughout.
4. Slave model. A mode-0 slave returns 0x5A, changing on sck falling edges → rx_data=0x5A. Repeat with CLK_DIV=3 → 0x5A.
5. Reset mid-transfer. Assert rst after the 3rd sck rise → next edge shows cs=2'b11, sck=0, and no rx_valid. A subsequent 0x81 transfer completes with the correct rx.
6. Stall and protocol checks. Stall in WAIT_NEXT for 100 cycles → cs stays low, sck=0, busy=1. tx_valid held during HIGH/LOW is not accepted (tx_ready=0). cs_sel=3 with NUM_CS=2 → no cs asserts and rx_valid still fires.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Chip select is held across multi-byte bursts and released after the byte flagged last.
module spi_master_ctrl #(
  parameter int CLK_DIV = 25,
  parameter int NUM_CS  = 2,
  parameter int CSW     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [7:0]        tx_data,
  input  logic              tx_last,
  input  logic [CSW-1:0]    tx_cs_sel,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LD_HALF  = CW'(CLK_DIV - 1);
  // The accept cycle already counts as the first sck-low cycle, so the first byte
  // rise lands CLK_DIV cycles after the handshake and DONE lands 17*CLK_DIV after it.
  localparam logic [CW-1:0] LD_SETUP = CW'(CLK_DIV - 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_HIGH      = 3'd2,
    S_LOW       = 3'd3,
    S_DONE      = 3'd4,
    S_WAIT_NEXT = 3'd5,
    S_HOLD      = 3'd6,
    S_GAP       = 3'd7
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_bit;
  logic [7:0]          r_tx;
  logic                r_last;
  logic [7:0]          r_shift;
  logic [7:0]          r_rx_data;
  logic                r_rx_valid;
  logic                r_sck;
  logic                r_mosi;
  logic [NUM_CS-1:0]   r_cs;
  logic                r_miso_meta;
  logic                r_miso_sync;

  logic                w_tx_ready;
  logic                w_accept;
  logic [NUM_CS-1:0]   w_sel_mask;

  assign w_tx_ready = !rst && ((r_state == S_IDLE) || (r_state == S_WAIT_NEXT));
  assign w_accept   = tx_valid && w_tx_ready;

  // An out-of-range select yields an empty mask: the byte still clocks, no device is selected.
  always_comb begin
    w_sel_mask = '0;
    for (int unsigned k = 0; k < NUM_CS; k++) begin
      w_sel_mask[k] = (32'(tx_cs_sel) == k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_miso_meta <= miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_last     <= 1'b0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs       <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cs  <= '1;
          r_sck <= 1'b0;
          if (w_accept) begin
            r_tx    <= tx_data;
            r_last  <= tx_last;
            r_cs    <= ~w_sel_mask;
            r_mosi  <= tx_data[7];
            r_cnt   <= LD_SETUP;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (r_cnt == '0) begin
            r_sck   <= 1'b1;
            r_bit   <= 3'd7;
            r_cnt   <= LD_HALF;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_HIGH: begin
          if (r_cnt == '0) begin
            r_shift <= {r_shift[6:0], r_miso_sync};
            r_sck   <= 1'b0;
            if (r_bit != 3'd0) begin
              r_mosi <= r_tx[r_bit - 3'd1];
            end
            r_cnt   <= LD_HALF;
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_LOW: begin
          if (r_cnt == '0) begin
            if (r_bit == 3'd0) begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_shift;
              r_state    <= S_DONE;
            end else begin
              r_bit   <= r_bit - 3'd1;
              r_sck   <= 1'b1;
              r_cnt   <= LD_HALF;
              r_state <= S_HIGH;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_DONE: begin
          if (r_last) begin
            r_cnt   <= LD_HALF;
            r_state <= S_HOLD;
          end else begin
            r_state <= S_WAIT_NEXT;
          end
        end

        S_WAIT_NEXT: begin
          r_sck <= 1'b0;
          if (w_accept) begin
            r_tx    <= tx_data;
            r_last  <= tx_last;
            r_mosi  <= tx_data[7];
            r_cnt   <= LD_SETUP;
            r_state <= S_SETUP;
          end
        end

        S_HOLD: begin
          if (r_cnt == '0) begin
            r_cs    <= '1;
            r_cnt   <= LD_HALF;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  assign tx_ready = w_tx_ready;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign busy     = (r_state != S_IDLE);
  assign state_o  = r_state;
  assign sck      = r_sck;
  assign mosi     = r_mosi;
  assign cs       = r_cs;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized bench for spi_master_ctrl: a mode-0 slave/loopback source on miso and
// a transaction-level model predicting rx bytes, mosi bit order, latency and cs timing.
module tb_spi_master_ctrl;

  localparam int D  = 4;
  localparam int D3 = 3;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic [1:0] tx_cs_sel;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic [2:0] state_o;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [1:0] cs;

  spi_master_ctrl #(.CLK_DIV(D), .NUM_CS(2), .CSW(2)) u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_cs_sel(tx_cs_sel), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .state_o(state_o), .sck(sck), .mosi(mosi), .miso(miso), .cs(cs)
  );

  logic       tx_valid3;
  logic       tx_ready3;
  logic [7:0] tx_data3;
  logic       tx_last3;
  logic [0:0] tx_cs_sel3;
  logic       rx_valid3;
  logic [7:0] rx_data3;
  logic       busy3;
  logic [2:0] state3;
  logic       sck3;
  logic       mosi3;
  logic       miso3;
  logic [1:0] cs3;

  spi_master_ctrl #(.CLK_DIV(D3), .NUM_CS(2), .CSW(1)) u_dut3 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid3), .tx_ready(tx_ready3), .tx_data(tx_data3),
    .tx_last(tx_last3), .tx_cs_sel(tx_cs_sel3), .rx_valid(rx_valid3), .rx_data(rx_data3),
    .busy(busy3), .state_o(state3), .sck(sck3), .mosi(mosi3), .miso(miso3), .cs(cs3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus monitors and mode-0 slave: slave bit index = sck falls since the byte was accepted.
  int         sck_rises = 0;
  int         sck_falls = 0;
  int         cs0_rises = 0;
  int         cs1_rises = 0;
  logic [7:0] mon_shift = '0;
  logic       loopback;
  logic [7:0] slv_byte;
  int         slv_base;

  always @(posedge sck) begin
    sck_rises++;
    mon_shift = {mon_shift[6:0], mosi};
  end
  always @(negedge sck) sck_falls++;
  always @(posedge cs[0]) cs0_rises++;
  always @(posedge cs[1]) cs1_rises++;

  always_comb begin
    int idx;
    idx = sck_falls - slv_base;
    if (loopback)                miso = mosi;
    else if (idx > 7 || idx < 0) miso = slv_byte[0];
    else                         miso = slv_byte[3'(7 - idx)];
  end

  int         falls3 = 0;
  int         base3;
  logic [7:0] slv3;
  always @(negedge sck3) falls3++;
  always_comb begin
    int idx;
    idx = falls3 - base3;
    if (idx > 7 || idx < 0) miso3 = slv3[0];
    else                    miso3 = slv3[3'(7 - idx)];
  end

  task automatic do_burst(input int n, input logic [1:0] sel, input bit loop, input bit fix,
                          input logic [7:0] fix_tx, input logic [7:0] fix_slv,
                          input bit hold_valid, input int stall);
    logic [7:0] tx, slv, exp_rx;
    logic [1:0] exp_cs;
    int         c0, c1, rb, k;
    bit         ok, rdy;
    exp_cs   = (sel < 2) ? ~(2'b01 << sel) : 2'b11;
    c0       = cs0_rises;
    c1       = cs1_rises;
    loopback = loop;
    for (int b = 0; b < n; b++) begin
      tx        = fix ? fix_tx : 8'($urandom);
      slv       = fix ? fix_slv : 8'($urandom);
      exp_rx    = loop ? tx : slv;
      tx_valid  = 1'b1;
      tx_data   = tx;
      tx_last   = (b == n - 1);
      tx_cs_sel = (b == 0) ? sel : 2'($urandom);
      ok = 1'b0;
      for (int w = 0; w < 200 && !ok; w++) begin
        @(negedge clk);
        if (tx_ready) ok = 1'b1;
      end
      chk("accept", 32'(ok), 1);
      tick();
      slv_byte = slv;
      slv_base = sck_falls;
      rb       = sck_rises;
      tx_valid = hold_valid;
      tx_data  = ~tx;
      tx_last  = 1'b0;
      k = 0; ok = 1'b0; rdy = 1'b0;
      while (!ok && k < 20 * D) begin
        tick();
        k++;
        if (tx_ready) rdy = 1'b1;
        if (rx_valid) ok = 1'b1;
      end
      tx_valid = 1'b0;
      chk("rx_valid_seen", 32'(ok), 1);
      // k counts edges from the accept edge; the accept cycle itself precedes that edge.
      chk("latency", k, 17 * D - 1);
      chk("ready_while_busy", 32'(rdy), 0);
      chk("rx_data", rx_data, exp_rx);
      chk("sck_rises", sck_rises - rb, 8);
      chk("mosi_bits", mon_shift, tx);
      chk("cs_during", cs, exp_cs);
      chk("state_done", state_o, 4);
      chk("busy_done", busy, 1);
      tick();
      chk("rx_pulse", rx_valid, 0);
      if (b != n - 1) begin
        chk("state_wait", state_o, 5);
        repeat (stall) tick();
        chk("wait_cs", cs, exp_cs);
        chk("wait_sck", sck, 0);
        chk("wait_busy", busy, 1);
        chk("wait_ready", tx_ready, 1);
      end
    end
    repeat (3) tick();
    chk("hold_cs", cs, exp_cs);
    tick();
    chk("cs_release", cs, 2'b11);
    chk("state_gap", state_o, 7);
    repeat (3) tick();
    chk("gap_ready", tx_ready, 0);
    tick();
    chk("idle_ready", tx_ready, 1);
    chk("idle_busy", busy, 0);
    chk("cs0_rises", cs0_rises - c0, (exp_cs[0] == 1'b0) ? 1 : 0);
    chk("cs1_rises", cs1_rises - c1, (exp_cs[1] == 1'b0) ? 1 : 0);
  endtask

  task automatic dut3_byte(input logic [7:0] slv);
    int k;
    bit ok;
    tx_valid3  = 1'b1;
    tx_data3   = 8'($urandom);
    tx_last3   = 1'b1;
    tx_cs_sel3 = 1'b0;
    ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      if (tx_ready3) ok = 1'b1;
    end
    chk("d3_accept", 32'(ok), 1);
    tick();
    slv3      = slv;
    base3     = falls3;
    tx_valid3 = 1'b0;
    k = 0; ok = 1'b0;
    while (!ok && k < 20 * D3) begin
      tick();
      k++;
      if (rx_valid3) ok = 1'b1;
    end
    chk("d3_rx_seen", 32'(ok), 1);
    chk("d3_latency", k, 17 * D3 - 1);
    chk("d3_rx_data", rx_data3, slv);
    chk("d3_cs", cs3, 2'b10);
    repeat (12) tick();
    chk("d3_idle", state3, 0);
  endtask

  initial begin
    int  rb;
    bit  ok, seen;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0; tx_cs_sel = '0;
    tx_valid3 = 1'b0; tx_data3 = '0; tx_last3 = 1'b0; tx_cs_sel3 = '0;
    loopback = 1'b1; slv_byte = '0; slv_base = 0; slv3 = '0; base3 = 0;

    repeat (3) tick();
    chk("rst_cs", cs, 2'b11);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_state", state_o, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", tx_ready, 1);

    do_burst(1, 2'd0, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 0);
    do_burst(2, 2'd1, 1'b0, 1'b1, 8'h3C, 8'hFF, 1'b0, 0);
    do_burst(1, 2'd0, 1'b0, 1'b1, 8'h96, 8'h5A, 1'b0, 0);
    do_burst(3, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 100);
    do_burst(2, 2'd3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 2);

    for (int i = 0; i < 12; i++) begin
      do_burst(1 + int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'b0, 8'h00, 8'h00,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    end

    loopback  = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 8'($urandom);
    tx_last   = 1'b1;
    tx_cs_sel = 2'd0;
    ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      if (tx_ready) ok = 1'b1;
    end
    tick();
    rb = sck_rises;
    tx_valid = 1'b0;
    ok = 1'b0;
    for (int w = 0; w < 20 * D && !ok; w++) begin
      tick();
      if (sck_rises - rb == 3) ok = 1'b1;
    end
    chk("third_rise", 32'(ok), 1);
    rst = 1'b1;
    tick();
    chk("midrst_cs", cs, 2'b11);
    chk("midrst_sck", sck, 0);
    chk("midrst_state", state_o, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20 * D) begin
      tick();
      if (rx_valid) seen = 1'b1;
    end
    chk("no_partial_rx", 32'(seen), 0);
    do_burst(1, 2'd0, 1'b1, 1'b1, 8'h81, 8'h00, 1'b0, 0);

    dut3_byte(8'h5A);
    dut3_byte(8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
